// File: rtl/vga_frame_capture.sv
// VGA receive-side frame grabber: tracks h/v position from the sync edges and writes one armed
// frame's image window, column-major, to a frame-buffer write port. Optional checksum: VGA_CAPTURE_CKSUM_EN.
`timescale 1ns/1ps
module vga_frame_capture #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int H_START    = 144,
    parameter int V_START    = 35,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 320
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en_i,
    input  logic              h_sync_i,
    input  logic              v_sync_i,
    input  logic [DATA_W-1:0] rgb_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic [15:0]       cksum_o
);

    localparam longint unsigned IMG_PIX  = longint'(IMG_WIDTH) * longint'(IMG_HEIGHT);
    localparam longint unsigned ADDR_CAP = 64'd1 << ADDR_W;

    generate
        if (IMG_PIX > ADDR_CAP) begin : g_size_chk
            $error("vga_frame_capture: IMG_WIDTH*IMG_HEIGHT exceeds the address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              hs_q, vs_q;
    logic [10:0]       h_cnt_q, h_cnt_d;
    logic [9:0]        v_cnt_q, v_cnt_d;
    logic              hs_rise, vs_rise;
    logic              in_win, is_last;
    logic [ADDR_W-1:0] col, row, addr_d;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              frame_err_q;
    logic              last_q;

    logic              wr_en, clr, set_err, last_set;

    // Position tracking; the counts describe the pixel being sampled in this cycle.
    always_comb begin
        hs_rise = pix_en_i & h_sync_i & ~hs_q;
        vs_rise = pix_en_i & v_sync_i & ~vs_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_i) begin
            if (hs_rise)
                h_cnt_d = '0;
            else if (h_cnt_q != '1)
                h_cnt_d = h_cnt_q + 11'd1;

            if (vs_rise)
                v_cnt_d = '0;
            else if (hs_rise && (v_cnt_q != '1))
                v_cnt_d = v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        in_win  = (int'(h_cnt_d) >= H_START) && (int'(h_cnt_d) < H_START + IMG_WIDTH) &&
                  (int'(v_cnt_d) >= V_START) && (int'(v_cnt_d) < V_START + IMG_HEIGHT);
        is_last = (int'(h_cnt_d) == H_START + IMG_WIDTH - 1) &&
                  (int'(v_cnt_d) == V_START + IMG_HEIGHT - 1);
        col     = ADDR_W'(h_cnt_d) - ADDR_W'(H_START);
        row     = ADDR_W'(v_cnt_d) - ADDR_W'(V_START);
        addr_d  = col * ADDR_W'(IMG_HEIGHT) + row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // last_q marks the cycle the final write is on the port, so DONE lands one clk later.
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        clr      = 1'b0;
        set_err  = 1'b0;
        last_set = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ARM;
                    clr     = 1'b1;
                end
            end
            ARM: begin
                busy_o = 1'b1;
                if (vs_rise)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                busy_o = 1'b1;
                if (last_q) begin
                    state_d = DONE;
                end else if (vs_rise) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end else if (pix_en_i && in_win) begin
                    wr_en    = 1'b1;
                    last_set = is_last;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_d = ARM;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            frame_err_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (pix_en_i) begin
                hs_q <= h_sync_i;
                vs_q <= v_sync_i;
            end
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            mem_we_q <= wr_en;
            last_q   <= last_set;
            if (wr_en) begin
                mem_addr_q  <= addr_d;
                mem_wdata_q <= rgb_i;
            end
            if (clr)
                frame_err_q <= 1'b0;
            else if (set_err)
                frame_err_q <= 1'b1;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign frame_err_o = frame_err_q;

`ifdef VGA_CAPTURE_CKSUM_EN
    logic [15:0] cksum_q;

    // Accumulates from the write port itself, so the sum matches exactly what memory received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cksum_q <= '0;
        else if (clr)
            cksum_q <= '0;
        else if (mem_we_q)
            cksum_q <= cksum_q + 16'(mem_wdata_q);
    end

    assign cksum_o = cksum_q;
`else
    assign cksum_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled-down raster; scoreboard of expected writes built from (h,v).
`timescale 1ns/1ps
module tb_vga_frame_capture;
    localparam int AW = 20, DW = 8;
    localparam int HS0 = 10, VS0 = 3, IW = 8, IH = 6;
    localparam int HT = 24, VT = 12, HSW = 4, VSW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic pix_en = 1'b0, h_sync = 1'b0, v_sync = 1'b0, start = 1'b0;
    logic [DW-1:0] rgb = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic mem_we, busy, done, frame_err;
    logic [15:0] cksum;

    always #5 clk = ~clk;

    vga_frame_capture #(
        .ADDR_W(AW), .DATA_W(DW), .H_START(HS0), .V_START(VS0),
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en_i(pix_en), .h_sync_i(h_sync), .v_sync_i(v_sync),
        .rgb_i(rgb), .start_i(start), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .busy_o(busy), .done_o(done), .frame_err_o(frame_err), .cksum_o(cksum)
    );

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int h; int v; int addr; int data; } vec_t;

    wr_t            exp_q[$];
    logic [DW-1:0]  memimg [int];
    int             checks = 0, errors = 0;
    int             wcount = 0;
    bit             fin_next = 1'b0;
    logic           pe_smp = 1'b0;
    logic [15:0]    exp_sum = '0;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) pe_smp <= pix_en;

    always @(negedge clk) begin
        wr_t e;
        if (fin_next) begin
            chk("done_after_last_we", done, 1);
            chk("busy_after_last_we", busy, 0);
            fin_next = 1'b0;
        end
        if (mem_we) begin
            wcount++;
            chk("we_follows_pix_en", pe_smp, 1);
            memimg[int'(mem_addr)] = mem_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h, no write required", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
            if (int'(mem_addr) == IW*IH-1) begin
                chk("done_low_at_last_we", done, 0);
                chk("busy_high_at_last_we", busy, 1);
                fin_next = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cksum", cksum, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        pix_en = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        exp_sum = '0;
    endtask

    // One generator pixel; idle cycles carry junk syncs/data when gaps are on.
    task automatic pix(int h, int v, bit gaps, bit novs, logic [DW-1:0] d, bit st);
        int g;
        g = gaps ? int'($urandom_range(0, 3)) : 1;
        repeat (g) begin
            pix_en = 1'b0;
            if (gaps) begin
                h_sync = 1'($urandom);
                v_sync = 1'($urandom);
                rgb    = 8'($urandom);
            end
            tick();
        end
        pix_en = 1'b1;
        h_sync = (h < HSW);
        v_sync = !novs && (v < VSW);
        rgb    = d;
        start  = st;
        tick();
        start  = 1'b0;
    endtask

    // pat: 0 -> (h+v), 1 -> constant 1, else random
    task automatic frame(int lines, bit cap, bit gaps, int pat, bit novs, bit st_first, int rst_line);
        logic [DW-1:0] d;
        wcount = 0;
        for (int v = 0; v < lines; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (v == rst_line && h == HS0 + 3) begin
                    do_reset();
                    cap = 1'b0;
                end
                case (pat)
                    0:       d = 8'(h + v);
                    1:       d = 8'h01;
                    default: d = 8'($urandom);
                endcase
                if (cap && h >= HS0 && h < HS0 + IW && v >= VS0 && v < VS0 + IH) begin
                    exp_q.push_back('{addr: AW'((h - HS0) * IH + (v - VS0)), data: d});
                    exp_sum = exp_sum + 16'(d);
                end
                pix(h, v, gaps, novs, d, st_first && v == 0 && h == 0);
            end
        end
        pix_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_cksum(string nm);
`ifdef VGA_CAPTURE_CKSUM_EN
        chk(nm, cksum, exp_sum);
`else
        chk(nm, cksum, 0);
`endif
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{h: 10, v: 3, addr: 0,  data: 8'h0D};
        tbl[1] = '{h: 11, v: 3, addr: 6,  data: 8'h0E};
        tbl[2] = '{h: 10, v: 4, addr: 1,  data: 8'h0E};
        tbl[3] = '{h: 17, v: 8, addr: 47, data: 8'h19};

        rst_n = 1'b0;
        tick();
        tick();
        chk("init_mem_we", mem_we, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_frame_err", frame_err, 0);
        chk("init_cksum", cksum, 0);
        rst_n = 1'b1;
        tick();

        // Unarmed frame: nothing written
        frame(VT, 0, 0, 0, 0, 0, -1);
        chk("idle_writes", wcount, 0);
        chk("idle_busy", busy, 0);

        // Full frame, rgb=(h+v)
        pulse_start();
        chk("arm_busy", busy, 1);
        chk("arm_done", done, 0);
        memimg.delete();
        frame(VT, 1, 0, 0, 0, 0, -1);
        chk("full_writes", wcount, IW*IH);
        chk("full_q_empty", exp_q.size(), 0);
        chk("full_done", done, 1);
        chk("full_busy", busy, 0);
        chk("full_frame_err", frame_err, 0);
        chk_cksum("full_cksum");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tbl%0d_h%0d_v%0d_present", i, tbl[i].h, tbl[i].v), memimg.exists(tbl[i].addr), 1);
            if (memimg.exists(tbl[i].addr))
                chk($sformatf("tbl%0d_h%0d_v%0d_data", i, tbl[i].h, tbl[i].v), memimg[tbl[i].addr], tbl[i].data);
        end

        // Truncated frame: v_sync returns after two image lines
        pulse_start();
        frame(VS0 + 2, 1, 0, 0, 0, 0, -1);
        chk("trunc_writes", wcount, 2*IW);
        chk("trunc_busy", busy, 1);
        frame(VT, 0, 0, 0, 0, 0, -1);
        chk("trunc_frame_err", frame_err, 1);
        chk("trunc_busy_after", busy, 0);
        chk("trunc_done", done, 0);
        chk("trunc_after_writes", wcount, 0);
        chk("trunc_q_empty", exp_q.size(), 0);

        // start coincident with vs_rise in IDLE: arms only, this frame is skipped
        exp_sum = '0;
        frame(VT, 0, 0, 0, 0, 1, -1);
        chk("coinc_busy", busy, 1);
        chk("coinc_err_cleared", frame_err, 0);
        chk("coinc_writes", wcount, 0);

        // Random strobe gaps and random pixel data
        frame(VT, 1, 1, 2, 0, 0, -1);
        chk("gap_writes", wcount, IW*IH);
        chk("gap_q_empty", exp_q.size(), 0);
        chk("gap_done", done, 1);
        chk_cksum("gap_cksum");

        // Constant data checksum
        pulse_start();
        chk("rearm_done", done, 0);
        chk("rearm_busy", busy, 1);
        chk("rearm_cksum_clr", cksum, 0);
        frame(VT, 1, 0, 1, 0, 0, -1);
        chk("ones_writes", wcount, IW*IH);
        chk_cksum("ones_cksum");

        // No v_sync: armed forever, nothing written
        pulse_start();
        frame(VT, 0, 0, 0, 1, 0, -1);
        chk("nosync_busy", busy, 1);
        chk("nosync_done", done, 0);
        chk("nosync_writes", wcount, 0);

        // Reset in the middle of a capture
        frame(VT, 1, 0, 0, 0, 0, VS0 + 2);
        chk("rst_mid_writes", wcount, 2*IW + 2);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        frame(VT, 0, 0, 0, 0, 0, -1);
        chk("post_rst_writes", wcount, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
